// File: rtl/gate3_sweep_ctrl_if.sv
// Handshake/result bundle between a sweep sequencer (master) and gate3_sweep_ctrl (slave).
// Stop exists only when GATE3_SWEEP_LOOP_EN is defined.
interface gate3_sweep_ctrl_if #(
  parameter int unsigned ERRW = 4
);
  logic            Start;
  logic            DutOut;
  logic            VecA;
  logic            VecB;
  logic            VecC;
  logic            Busy;
  logic            Done;
  logic            Pass;
  logic [ERRW-1:0] ErrCnt;
  logic [2:0]      FailVec;
  logic            FailValid;
`ifdef GATE3_SWEEP_LOOP_EN
  logic            Stop;
`endif

  modport master (
`ifdef GATE3_SWEEP_LOOP_EN
    output Stop,
`endif
    output Start, DutOut,
    input  VecA, VecB, VecC, Busy, Done, Pass, ErrCnt, FailVec, FailValid
  );

  modport slave (
`ifdef GATE3_SWEEP_LOOP_EN
    input  Stop,
`endif
    input  Start, DutOut,
    output VecA, VecB, VecC, Busy, Done, Pass, ErrCnt, FailVec, FailValid
  );
endinterface

// File: rtl/gate3_sweep_ctrl.sv
// Sweeps a 3-input gate through all 8 input vectors and checks its output against TRUTH.
// Define GATE3_SWEEP_LOOP_EN to repeat passes until Stop is seen.
module gate3_sweep_ctrl #(
  parameter int unsigned DWELL = 4,
  parameter logic [7:0]  TRUTH = 8'b1000_0000,
  parameter int unsigned ERRW  = 4
) (
  input logic               Clk,
  input logic               Reset,
  gate3_sweep_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned    DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0]  DWELL_LAST = DW'(DWELL - 1);

  state_t            state_r;
  state_t            state_s;
  logic [2:0]        vec_r;
  logic [DW-1:0]     dwell_r;
  logic [ERRW-1:0]   err_r;
  logic              pass_r;
  logic [2:0]        fail_vec_r;
  logic              fail_valid_r;
  logic              busy_r;
  logic              done_r;
  logic              busy_s;
  logic              done_s;
  logic              mismatch_s;
  logic              last_s;
  logic              wrap_s;
  logic [ERRW-1:0]   err_next_s;

  function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + ERRW'(1'b1);
    end
  endfunction

  // Compare and wrap decisions for the current SAMPLE cycle
  always_comb begin
    mismatch_s = (state_r == SAMPLE) && (bus.DutOut != TRUTH[vec_r]);
    last_s     = (vec_r == 3'd7);
    if (mismatch_s) begin
      err_next_s = sat_inc(err_r);
    end else begin
      err_next_s = err_r;
    end
  end

`ifdef GATE3_SWEEP_LOOP_EN
  logic stop_r;

  // Sticky stop request, armed only while a sweep is running
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stop_r <= 1'b0;
    end else if ((state_r == IDLE) && bus.Start) begin
      stop_r <= 1'b0;
    end else if (busy_r && bus.Stop) begin
      stop_r <= 1'b1;
    end
  end

  assign wrap_s = last_s && !stop_r;
`else
  assign wrap_s = 1'b0;
`endif

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (bus.Start) state_s = APPLY; else state_s = IDLE;
      APPLY:   if (dwell_r == DWELL_LAST) state_s = SAMPLE; else state_s = APPLY;
      SAMPLE:  if (last_s && !wrap_s) state_s = DONE; else state_s = APPLY;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Status outputs decoded from the upcoming state so they register in step with it
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_s)
      APPLY:   busy_s = 1'b1;
      SAMPLE:  busy_s = 1'b1;
      DONE:    done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Status output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_s;
      done_r <= done_s;
    end
  end

  // Vector, dwell and result datapath
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vec_r        <= 3'd0;
      dwell_r      <= {DW{1'b0}};
      err_r        <= {ERRW{1'b0}};
      pass_r       <= 1'b0;
      fail_vec_r   <= 3'd0;
      fail_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.Start) begin
            vec_r        <= 3'd0;
            dwell_r      <= {DW{1'b0}};
            err_r        <= {ERRW{1'b0}};
            pass_r       <= 1'b0;
            fail_vec_r   <= 3'd0;
            fail_valid_r <= 1'b0;
          end
        end
        APPLY: begin
          dwell_r <= dwell_r + DW'(1'b1);
        end
        SAMPLE: begin
          err_r   <= err_next_s;
          dwell_r <= {DW{1'b0}};
          if (mismatch_s && !fail_valid_r) begin
            fail_vec_r   <= vec_r;
            fail_valid_r <= 1'b1;
          end
          // Pass reflects the count including this final compare
          if (last_s && !wrap_s) begin
            vec_r  <= 3'd0;
            pass_r <= (err_next_s == {ERRW{1'b0}});
          end else begin
            vec_r <= vec_r + 3'd1;
          end
        end
        DONE: begin
          vec_r <= 3'd0;
        end
        default: begin
          vec_r <= 3'd0;
        end
      endcase
    end
  end

  assign bus.VecA      = vec_r[2];
  assign bus.VecB      = vec_r[1];
  assign bus.VecC      = vec_r[0];
  assign bus.Busy      = busy_r;
  assign bus.Done      = done_r;
  assign bus.Pass      = pass_r;
  assign bus.ErrCnt    = err_r;
  assign bus.FailVec   = fail_vec_r;
  assign bus.FailValid = fail_valid_r;
endmodule

// File: tb/tb_gate3_sweep_ctrl.sv
// Directed bench for gate3_sweep_ctrl: AND3 / stuck-at gates, saturation, restart and reset cases.
// Build with GATE3_SWEEP_LOOP_EN to add the multi-pass case.
module tb_gate3_sweep_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   mode;
  int   checks = 0;
  int   errors = 0;
  int   fb, lb, dc, pa;

  always #5 clk = ~clk;

  gate3_sweep_ctrl_if #(.ERRW(4)) sweep_bus ();
  gate3_sweep_ctrl_if #(.ERRW(2)) sat_bus ();

  gate3_sweep_ctrl #(.DWELL(4), .TRUTH(8'h80), .ERRW(4)) u_dut (
    .Clk(clk), .Reset(rst), .bus(sweep_bus)
  );
  gate3_sweep_ctrl #(.DWELL(2), .TRUTH(8'h80), .ERRW(2)) u_sat (
    .Clk(clk), .Reset(rst), .bus(sat_bus)
  );

  // Gate model: 0 = AND3, 1 = stuck at 0, 2 = stuck at 1
  assign sweep_bus.DutOut = (mode == 0) ? (sweep_bus.VecA & sweep_bus.VecB & sweep_bus.VecC)
                          : (mode == 1) ? 1'b0 : 1'b1;
  assign sat_bus.DutOut   = 1'b1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start in relative cycle 0; optional extra Start / Stop pulses; returns at IDLE
  task automatic sweep(input int restart_at, input int stop_at,
                       output int first_b, output int last_b, output int done_c, output int pass_v);
    first_b = -1; last_b = -1; done_c = -1; pass_v = -1;
    sweep_bus.Start = 1'b1;
    tick();
    for (int c = 1; c <= 200; c++) begin
      if (sweep_bus.Busy) begin
        if (first_b < 0) first_b = c;
        last_b = c;
      end
      if (sweep_bus.Done) begin
        done_c = c;
        pass_v = int'(sweep_bus.Pass);
        break;
      end
      sweep_bus.Start = (c == restart_at);
`ifdef GATE3_SWEEP_LOOP_EN
      sweep_bus.Stop = (c == stop_at);
`endif
      tick();
    end
    sweep_bus.Start = 1'b0;
`ifdef GATE3_SWEEP_LOOP_EN
    sweep_bus.Stop = 1'b0;
`endif
    tick();
  endtask

  initial begin
    rst = 1'b1;
    mode = 0;
    sweep_bus.Start = 1'b0;
    sat_bus.Start = 1'b0;
`ifdef GATE3_SWEEP_LOOP_EN
    sweep_bus.Stop = 1'b0;
    sat_bus.Stop = 1'b1;
`endif
    tick();
    tick();
    check("rst_busy", int'(sweep_bus.Busy), 0);
    check("rst_done", int'(sweep_bus.Done), 0);
    check("rst_vec", int'({sweep_bus.VecA, sweep_bus.VecB, sweep_bus.VecC}), 0);
    check("rst_pass", int'(sweep_bus.Pass), 0);
    check("rst_errcnt", int'(sweep_bus.ErrCnt), 0);
    check("rst_failvec", int'(sweep_bus.FailVec), 0);
    check("rst_failvalid", int'(sweep_bus.FailValid), 0);
    rst = 1'b0;
    tick();

    // AND3 matches TRUTH: clean pass
    mode = 0;
    sweep(-1, 1, fb, lb, dc, pa);
    check("and3_busy_first", fb, 1);
    check("and3_busy_last", lb, 40);
    check("and3_done_cycle", dc, 41);
    check("and3_pass", pa, 1);
    check("and3_errcnt", int'(sweep_bus.ErrCnt), 0);
    check("and3_failvalid", int'(sweep_bus.FailValid), 0);
    check("idle_vec", int'({sweep_bus.VecA, sweep_bus.VecB, sweep_bus.VecC}), 0);

    // Stuck at 0: only vector 7 mismatches
    mode = 1;
    sweep(-1, 1, fb, lb, dc, pa);
    check("st0_done_cycle", dc, 41);
    check("st0_pass", pa, 0);
    check("st0_errcnt", int'(sweep_bus.ErrCnt), 1);
    check("st0_failvec", int'(sweep_bus.FailVec), 7);
    check("st0_failvalid", int'(sweep_bus.FailValid), 1);
    tick();
    check("hold_done", int'(sweep_bus.Done), 0);
    check("hold_errcnt", int'(sweep_bus.ErrCnt), 1);
    check("hold_pass", int'(sweep_bus.Pass), 0);

    // Stuck at 1 on a 2-bit counter: 7 mismatches saturate at 3
    sat_bus.Start = 1'b1;
    tick();
    sat_bus.Start = 1'b0;
    dc = -1;
    for (int c = 1; c <= 100; c++) begin
      if (sat_bus.Done) begin
        dc = c;
        break;
      end
      tick();
    end
    check("sat_done_cycle", dc, 25);
    check("sat_errcnt", int'(sat_bus.ErrCnt), 3);
    check("sat_failvec", int'(sat_bus.FailVec), 0);
    check("sat_failvalid", int'(sat_bus.FailValid), 1);
    check("sat_pass", int'(sat_bus.Pass), 0);
    tick();

    // Start during a sweep is ignored
    mode = 0;
    sweep(10, 1, fb, lb, dc, pa);
    check("restart_ignored_done", dc, 41);
    check("restart_ignored_pass", pa, 1);

    // Reset in the middle of vector 3
    mode = 2;
    sweep_bus.Start = 1'b1;
    tick();
    sweep_bus.Start = 1'b0;
    for (int c = 1; c < 18; c++) begin
      if (c == 16) begin
        check("mid_vec3", int'({sweep_bus.VecA, sweep_bus.VecB, sweep_bus.VecC}), 3);
        check("mid_errcnt", int'(sweep_bus.ErrCnt), 3);
      end
`ifdef GATE3_SWEEP_LOOP_EN
      sweep_bus.Stop = (c == 1);
`endif
      tick();
    end
`ifdef GATE3_SWEEP_LOOP_EN
    sweep_bus.Stop = 1'b0;
`endif
    rst = 1'b1;
    tick();
    check("midrst_busy", int'(sweep_bus.Busy), 0);
    check("midrst_vec", int'({sweep_bus.VecA, sweep_bus.VecB, sweep_bus.VecC}), 0);
    check("midrst_errcnt", int'(sweep_bus.ErrCnt), 0);
    check("midrst_failvalid", int'(sweep_bus.FailValid), 0);
    rst = 1'b0;
    mode = 0;
    tick();
    sweep(-1, 1, fb, lb, dc, pa);
    check("midrst_restart_done", 20 + dc, 61);
    check("midrst_restart_pass", pa, 1);

    // Reset wins over Start
    rst = 1'b1;
    sweep_bus.Start = 1'b1;
    tick();
    check("rst_prio_busy", int'(sweep_bus.Busy), 0);
    rst = 1'b0;
    sweep_bus.Start = 1'b0;
    tick();
    check("rst_prio_idle", int'(sweep_bus.Busy), 0);

`ifdef GATE3_SWEEP_LOOP_EN
    // Two passes: Stop during the second pass ends the sweep
    sweep(-1, 60, fb, lb, dc, pa);
    check("loop_busy_last", lb, 80);
    check("loop_done_cycle", dc, 81);
    check("loop_pass", pa, 1);
    check("loop_errcnt", int'(sweep_bus.ErrCnt), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
